conv1_sched: RTL and testbench

Frame scheduler and result buffer for the `conv1` 3x3 convolution datapath. It fetches one 28x3 frame of 16-bit pixels from an external pixel store and drives `data_in`/`row`/`col` into the engine in raster order. It captures the engine's 32-bit results, qualified by `wdata_fin`, into an internal FIFO that drains over a valid/ready output port. Issue is throttled by credits so a stalled consumer can never overflow the FIFO.

---
 rtl/conv1_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_conv1_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_sched.sv
// conv1_sched
// Frame scheduler and result buffer for the conv1 3x3 convolution engine.
// Fetches one ROWS x COLS frame of 16-bit pixels from an external store in
// raster order, hands each pixel to the engine, and buffers the engine's
// 32-bit results in a first-word-fall-through FIFO drained by valid/ready.
// Pixel issue is throttled by credits so a stalled consumer never overflows
// the FIFO.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          begin a frame (IDLE only) / cancel and flush
//   busy, done            frame in progress / one-cycle completion pulse
//   overflow              sticky: a result arrived while the FIFO was full
//   frame_cnt             completed frames, wraps at 255
//   pix_req/pix_addr      pixel read request and address (row*COLS+col)
//   pix_valid/pix_data    pixel store handshake and data
//   eng_data/row/col      registered pixel and position to the engine
//   eng_res_valid/eng_res engine result strobe (wdata_fin) and data
//   out_valid/out_data    FIFO head, out_ready pops it
module conv1_sched #(
  parameter int ROWS       = 28,
  parameter int COLS       = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [7:0]                     frame_cnt,
  output logic                           pix_req,
  output logic [$clog2(ROWS*COLS)-1:0]   pix_addr,
  input  logic                           pix_valid,
  input  logic [15:0]                    pix_data,
  output logic [15:0]                    eng_data,
  output logic [$clog2(ROWS)-1:0]        eng_row,
  output logic [$clog2(COLS)-1:0]        eng_col,
  input  logic                           eng_res_valid,
  input  logic [31:0]                    eng_res,
  output logic                           out_valid,
  output logic [31:0]                    out_data,
  input  logic                           out_ready
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int AW    = $clog2(ROWS*COLS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CRW   = PW + 1;
  localparam int TOTAL = (ROWS - 2) * COLS;
  localparam int RCW   = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t          state;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [RCW-1:0]  res_cnt;
  logic [CRW-1:0]  credits;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CRW-1:0]  fill;

  logic abort_act;
  logic result_pos;
  logic last_pos;
  logic hs;
  logic issue_rp;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // abort only has an effect while a frame is in flight
  assign abort_act  = abort && (state != IDLE);
  assign result_pos = (row_q >= RW'(2));
  assign last_pos   = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  // Non-producing positions never consume FIFO space, so they issue freely
  assign pix_req  = (state == FETCH) && (!result_pos || (credits != '0));
  assign pix_addr = AW'(int'(row_q) * COLS + int'(col_q));

  // A handshake in the abort cycle is discarded
  assign hs       = pix_req && pix_valid && !abort_act;
  assign issue_rp = hs && result_pos;

  assign out_valid = (fill != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;
  assign full      = (fill == CRW'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  // A simultaneous pop makes room, so a push into a full FIFO is legal then
  assign push      = eng_res_valid && (!full || pop);
  assign drop      = eng_res_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push && !abort_act) begin
      mem[wr_ptr] <= eng_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (abort_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + CRW'(1);
        2'b01:   fill <= fill - CRW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Credits track FIFO slots not yet reserved by an issued result-producing
  // pixel; a slot comes back only when its result leaves the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= CRW'(FIFO_DEPTH);
    end else if (abort_act || (state == IDLE)) begin
      credits <= CRW'(FIFO_DEPTH);
    end else begin
      case ({pop, issue_rp})
        2'b10: begin
          if (credits != CRW'(FIFO_DEPTH)) begin
            credits <= credits + CRW'(1);
          end
        end
        2'b01: begin
          if (credits != '0) begin
            credits <= credits - CRW'(1);
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      res_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= 8'd0;
      eng_data  <= 16'h0;
      eng_row   <= '0;
      eng_col   <= '0;
    end else begin
      done <= 1'b0;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (eng_res_valid && ((state == FETCH) || (state == DRAIN))) begin
        res_cnt <= res_cnt + RCW'(1);
      end

      if (abort_act) begin
        state <= IDLE;
        busy  <= 1'b0;
        row_q <= '0;
        col_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= FETCH;
              busy    <= 1'b1;
              row_q   <= '0;
              col_q   <= '0;
              res_cnt <= '0;
            end
          end
          FETCH: begin
            if (hs) begin
              eng_data <= pix_data;
              eng_row  <= row_q;
              eng_col  <= col_q;
              if (last_pos) begin
                state <= DRAIN;
                row_q <= '0;
                col_q <= '0;
              end else if (col_q == CW'(COLS - 1)) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
          DRAIN: begin
            if ((res_cnt == RCW'(TOTAL)) && (fill == '0)) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv1_sched.sv
// tb_conv1_sched
// Self-checking bench for conv1_sched. The bench plays both the pixel store
// and the conv1 engine: the engine model computes each result from the
// eng_* values the DUT actually delivered, while a scoreboard holds golden
// results computed from the bench's own pixel memory and compares them as
// the DUT pops them out of its FIFO.
module tb_conv1_sched;

  localparam int ROWS  = 28;
  localparam int COLS  = 3;
  localparam int DEPTH = 8;
  localparam int NPIX  = ROWS * COLS;
  localparam int NRES  = (ROWS - 2) * COLS;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  frame_cnt;
  logic        pix_req;
  logic [6:0]  pix_addr;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [15:0] eng_data;
  logic [4:0]  eng_row;
  logic [1:0]  eng_col;
  logic        eng_res_valid;
  logic [31:0] eng_res;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  always #5 clk = ~clk;

  conv1_sched #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .overflow(overflow), .frame_cnt(frame_cnt),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid),
    .pix_data(pix_data), .eng_data(eng_data), .eng_row(eng_row),
    .eng_col(eng_col), .eng_res_valid(eng_res_valid), .eng_res(eng_res),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] pix_mem [NPIX];
  logic [15:0] eng_img [ROWS][COLS];
  logic [31:0] exp_q [$];
  logic [31:0] pipe_val [$];
  int          pipe_due [$];

  int          cyc = 0;
  int          valid_pct = 100;
  int          ready_pct = 100;
  int          next_addr = 0;
  int          pop_cnt = 0;
  int          done_cnt = 0;
  int          first_issue_cyc = 0;
  int          last_issue_cyc = 0;
  bit          inject = 1'b0;
  logic [31:0] inject_val = 32'h0;

  typedef struct {
    int validPct;
    int readyPct;
    int expPops;
    int expFrames;
    bit checkRate;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=expired required=event", name);
  endtask

  // Weighted vertical 3-tap per column plus a position tag
  function automatic logic [31:0] conv_val(input logic [15:0] p0, input logic [15:0] p1,
                                           input logic [15:0] p2, input int r, input int c);
    return 32'(p2) + 32'(p1) * 32'd2 + 32'(p0) * 32'd3 + 32'(r * 256 + c);
  endfunction

  task automatic flushModel();
    exp_q.delete();
    pipe_val.delete();
    pipe_due.delete();
    inject        = 1'b0;
    eng_res_valid = 1'b0;
    eng_res       = 32'h0;
    next_addr     = 0;
  endtask

  // One clock cycle: sample before the edge, check after it, drive next inputs
  task automatic applyStimulus();
    bit          hs;
    bit          pop;
    bit          req_before;
    logic [6:0]  addr_before;
    logic [31:0] pop_data;
    logic [15:0] ed;
    logic [4:0]  er;
    logic [1:0]  ec;
    int          exp_r;
    int          exp_c;
    int          rr;
    int          cc;
    @(negedge clk);
    hs          = pix_req && pix_valid && !abort && !reset;
    pop         = out_valid && out_ready && !abort && !reset;
    req_before  = pix_req;
    addr_before = pix_addr;
    pop_data    = out_data;
    ed = eng_data; er = eng_row; ec = eng_col;
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (hs) begin
      if (next_addr >= NPIX) begin
        checkOutput("extra_issue", 32'(addr_before), 32'(NPIX - 1));
      end else begin
        exp_r = next_addr / COLS;
        exp_c = next_addr % COLS;
        checkOutput("issue_addr", 32'(addr_before), 32'(next_addr));
        checkOutput("eng_data", 32'(eng_data), 32'(pix_mem[next_addr]));
        checkOutput("eng_pos", 32'({eng_row, eng_col}), 32'(exp_r * 4 + exp_c));
        rr = int'(eng_row);
        cc = int'(eng_col);
        if (rr < ROWS && cc < COLS) begin
          eng_img[rr][cc] = eng_data;
          if (rr >= 2) begin
            pipe_val.push_back(conv_val(eng_img[rr-2][cc], eng_img[rr-1][cc], eng_img[rr][cc], rr, cc));
            pipe_due.push_back(cyc + LAT);
          end
        end
        if (exp_r >= 2) begin
          exp_q.push_back(conv_val(pix_mem[(exp_r-2)*COLS + exp_c], pix_mem[(exp_r-1)*COLS + exp_c],
                                   pix_mem[next_addr], exp_r, exp_c));
        end
        if (next_addr == 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        next_addr++;
      end
    end else if (!abort && !reset) begin
      if (req_before) begin
        checkOutput("req_hold", 32'(pix_req), 32'd1);
        checkOutput("addr_hold", 32'(pix_addr), 32'(addr_before));
      end
      checkOutput("eng_hold", 32'({eng_data, eng_row, eng_col}), 32'({ed, er, ec}));
    end
    if (pop) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pop", pop_data, 32'hFFFF_FFFF);
      end else begin
        checkOutput("out_data", pop_data, exp_q.pop_front());
      end
    end
    if (inject) begin
      eng_res_valid = 1'b1;
      eng_res       = inject_val;
      inject        = 1'b0;
    end else if (pipe_due.size() > 0 && pipe_due[0] <= cyc) begin
      eng_res_valid = 1'b1;
      eng_res       = pipe_val.pop_front();
      void'(pipe_due.pop_front());
    end else begin
      eng_res_valid = 1'b0;
      eng_res       = 32'h0;
    end
    pix_valid = (int'($urandom_range(99)) < valid_pct);
    out_ready = (int'($urandom_range(99)) < ready_pct);
    pix_data  = (int'(pix_addr) < NPIX) ? pix_mem[int'(pix_addr)] : 16'h0;
  endtask

  task automatic startFrame();
    next_addr = 0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  task automatic waitDone(input int start_dones);
    int n = 0;
    while (done_cnt == start_dones && n < 4000) begin
      applyStimulus();
      n++;
    end
    if (n >= 4000) failNow("done_timeout");
    repeat (3) applyStimulus();
  endtask

  task automatic waitAddr(input int addr);
    int n = 0;
    while (next_addr < addr && n < 2000) begin
      applyStimulus();
      n++;
    end
    if (n >= 2000) failNow("addr_timeout");
  endtask

  task automatic doAbort();
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    flushModel();
  endtask

  vec_t vecs[4];

  initial begin
    int p0;
    int d0;
    int fc;

    vecs[0] = '{validPct: 100, readyPct: 100, expPops: NRES, expFrames: 1, checkRate: 1'b1};
    vecs[1] = '{validPct: 50,  readyPct: 100, expPops: NRES, expFrames: 2, checkRate: 1'b0};
    vecs[2] = '{validPct: 100, readyPct: 40,  expPops: NRES, expFrames: 3, checkRate: 1'b0};
    vecs[3] = '{validPct: 60,  readyPct: 30,  expPops: NRES, expFrames: 4, checkRate: 1'b0};

    for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'($urandom);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) eng_img[r][c] = 16'h0;

    reset = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
    eng_res_valid = 1'b0; eng_res = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_pix_req", 32'(pix_req), 32'd0);
    checkOutput("rst_pix_addr", 32'(pix_addr), 32'd0);
    checkOutput("rst_eng", 32'({eng_data, eng_row, eng_col}), 32'd0);
    checkOutput("rst_out", 32'({out_valid, out_data}), 32'd0);
    reset = 1'b0;
    applyStimulus();

    // Table-driven full frames under different handshake throttling
    foreach (vecs[k]) begin
      valid_pct = vecs[k].validPct;
      ready_pct = vecs[k].readyPct;
      p0 = pop_cnt;
      d0 = done_cnt;
      startFrame();
      checkOutput("busy_rise", 32'(busy), 32'd1);
      waitDone(d0);
      checkOutput("frame_pops", 32'(pop_cnt - p0), 32'(vecs[k].expPops));
      checkOutput("done_pulses", 32'(done_cnt - d0), 32'd1);
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(vecs[k].expFrames));
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      checkOutput("busy_fall", 32'(busy), 32'd0);
      if (vecs[k].checkRate)
        checkOutput("peak_rate", 32'(last_issue_cyc - first_issue_cyc + 1), 32'(NPIX));
    end

    // Backpressure: consumer stalled, credits stop issue after addr 13
    valid_pct = 100; ready_pct = 0; out_ready = 1'b0;
    p0 = pop_cnt; d0 = done_cnt;
    startFrame();
    repeat (30) applyStimulus();
    checkOutput("bp_stall_addr", 32'(next_addr), 32'd14);
    checkOutput("bp_pix_req", 32'(pix_req), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_held", 32'(exp_q.size()), 32'(DEPTH));
    ready_pct = 100; out_ready = 1'b1;
    waitDone(d0);
    checkOutput("bp_pops", 32'(pop_cnt - p0), 32'(NRES));
    checkOutput("bp_frame_cnt", 32'(frame_cnt), 32'd5);
    checkOutput("bp_overflow", 32'(overflow), 32'd0);

    // Abort at addr 40 with results sitting in the FIFO
    d0 = done_cnt;
    startFrame();
    waitAddr(40);
    valid_pct = 0; pix_valid = 1'b0; ready_pct = 0; out_ready = 1'b0;
    repeat (4) applyStimulus();
    checkOutput("ab_addr", 32'(pix_addr), 32'd40);
    checkOutput("ab_fifo_busy", 32'(out_valid), 32'd1);
    doAbort();
    checkOutput("ab_busy", 32'(busy), 32'd0);
    checkOutput("ab_out_valid", 32'(out_valid), 32'd0);
    checkOutput("ab_pix_req", 32'(pix_req), 32'd0);
    repeat (4) applyStimulus();
    checkOutput("ab_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("ab_frame_cnt", 32'(frame_cnt), 32'd5);
    valid_pct = 100; ready_pct = 100; out_ready = 1'b1;
    p0 = pop_cnt;
    startFrame();
    waitDone(d0);
    checkOutput("ab_next_pops", 32'(pop_cnt - p0), 32'(NRES));
    checkOutput("ab_next_frame_cnt", 32'(frame_cnt), 32'd6);

    // Extra result into a full FIFO is dropped and flags overflow
    valid_pct = 100; ready_pct = 0; out_ready = 1'b0;
    startFrame();
    repeat (30) applyStimulus();
    checkOutput("ov_before", 32'(overflow), 32'd0);
    checkOutput("ov_full", 32'(exp_q.size()), 32'(DEPTH));
    inject = 1'b1;
    inject_val = 32'hDEAD_BEEF;
    applyStimulus();
    applyStimulus();
    checkOutput("ov_set", 32'(overflow), 32'd1);
    p0 = pop_cnt;
    ready_pct = 100; out_ready = 1'b1;
    repeat (12) applyStimulus();
    checkOutput("ov_popped", 32'(pop_cnt - p0 >= DEPTH), 32'd1);
    checkOutput("ov_sticky", 32'(overflow), 32'd1);
    doAbort();
    checkOutput("ov_after_abort", 32'(overflow), 32'd1);
    fc = int'(frame_cnt);
    checkOutput("ov_frame_cnt", 32'(fc), 32'd6);

    // Reset in the middle of DRAIN
    valid_pct = 100; ready_pct = 100; out_ready = 1'b1;
    startFrame();
    waitAddr(NPIX);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    checkOutput("drain_pix_req", 32'(pix_req), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_overflow", 32'(overflow), 32'd0);
    checkOutput("mid_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("mid_ctl", 32'({done, pix_req, pix_addr}), 32'd0);
    checkOutput("mid_eng", 32'({eng_data, eng_row, eng_col}), 32'd0);
    checkOutput("mid_out", 32'({out_valid, out_data}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    flushModel();
    ready_pct = 0; out_ready = 1'b0;
    startFrame();
    repeat (30) applyStimulus();
    checkOutput("mid_credits", 32'(next_addr), 32'd14);
    doAbort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=expired required=finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
